// File: rtl/seg7_scan.sv
// Time-multiplexed 7-segment scanner: shadow-buffered hex digits, per-slot
// blanking guard, registered active-low anode/segment/dp drive.
module seg7_scan #(
    parameter int DIGITS        = 4,
    parameter int REFRESH_MAX   = 65535,
    parameter int REFRESH_WIDTH = 16,
    parameter int GUARD         = 256
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     enable,
    input  logic                                     load,
    input  logic [4*DIGITS-1:0]                      value,
    input  logic [DIGITS-1:0]                        dp_in,
    input  logic [DIGITS-1:0]                        blank_in,
    output logic [DIGITS-1:0]                        an,
    output logic [6:0]                               seg,
    output logic                                     dp,
    output logic [((DIGITS>1)?$clog2(DIGITS):1)-1:0] digit_idx,
    output logic                                     frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t                   state_q, state_d;
    logic [REFRESH_WIDTH-1:0] cnt, cnt_d;
    logic [IW-1:0]            idx_d;
    logic [4*DIGITS-1:0]      sh_val;
    logic [DIGITS-1:0]        sh_dp;
    logic [DIGITS-1:0]        sh_blank;
    logic [DIGITS-1:0]        an_d;
    logic [6:0]               seg_d;
    logic                     dp_d;
    logic                     fd_d;
    logic [3:0]               nib;
    logic [6:0]               dec;
    logic                     slot_end;

    always_comb begin
        nib = sh_val[4*int'(digit_idx) +: 4];
        case (nib)
            4'h0: dec = 7'h40;
            4'h1: dec = 7'h79;
            4'h2: dec = 7'h24;
            4'h3: dec = 7'h30;
            4'h4: dec = 7'h19;
            4'h5: dec = 7'h12;
            4'h6: dec = 7'h02;
            4'h7: dec = 7'h78;
            4'h8: dec = 7'h00;
            4'h9: dec = 7'h10;
            4'hA: dec = 7'h08;
            4'hB: dec = 7'h03;
            4'hC: dec = 7'h46;
            4'hD: dec = 7'h21;
            4'hE: dec = 7'h06;
            default: dec = 7'h0E;
        endcase
    end

    // State is decided from the current count; the registered outputs then
    // carry that decision, giving the one-cycle drive latency.
    always_comb begin
        state_d  = (cnt < REFRESH_WIDTH'(GUARD)) ? BLANK : DRIVE;
        slot_end = (cnt == REFRESH_WIDTH'(REFRESH_MAX));
        cnt_d    = cnt;
        idx_d    = digit_idx;
        fd_d     = 1'b0;
        an_d     = '1;
        seg_d    = 7'h7F;
        dp_d     = 1'b1;
        if (enable) begin
            cnt_d = slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx_d = (digit_idx == IW'(DIGITS-1)) ? '0 : digit_idx + 1'b1;
                fd_d  = (digit_idx == IW'(DIGITS-1));
            end
            if (state_d == DRIVE && !sh_blank[digit_idx]) begin
                an_d  = ~(DIGITS'(1) << digit_idx);
                seg_d = dec;
                dp_d  = ~sh_dp[digit_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BLANK;
            cnt        <= '0;
            digit_idx  <= '0;
            sh_val     <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt        <= cnt_d;
            digit_idx  <= idx_d;
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            frame_done <= fd_d;
            if (load) begin
                sh_val   <= value;
                sh_dp    <= dp_in;
                sh_blank <= blank_in;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: directed scenarios plus random traffic
// against a position-counting reference model.
module tb_seg7_scan;

    localparam int D  = 4;
    localparam int RM = 7;
    localparam int G  = 2;
    localparam int SL = RM + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    blank_in = '0;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic [1:0]    digit_idx;
    logic          frame_done;

    int vectors = 0;
    int miscompares = 0;

    // reference state: total enabled cycles since reset, plus shadow copies
    int          pos = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_blank = '0;

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan #(.DIGITS(D), .REFRESH_MAX(RM), .REFRESH_WIDTH(3), .GUARD(G)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .blank_in(blank_in), .an(an), .seg(seg), .dp(dp),
        .digit_idx(digit_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        int          slot, c;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp, e_fd;
        @(posedge clk);
        slot = (pos / SL) % D;
        c    = pos % SL;
        e_fd = enable && (pos % (SL*D) == SL*D-1);
        if (!enable || c < G || m_blank[slot]) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            e_an  = 4'hF & ~(4'b0001 << slot);
            e_seg = tbl[m_val[slot*4 +: 4]];
            e_dp  = ~m_dp[slot];
        end
        if (enable) pos++;
        if (load) begin
            m_val = value; m_dp = dp_in; m_blank = blank_in;
        end
        #1;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("digit_idx", 32'(digit_idx), 32'((pos / SL) % D));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic align(input int period, input int target);
        for (int i = 0; i < 2*period && (pos % period) != target; i++) tick();
        chk("align", 32'(pos % period), 32'(target));
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_fd", 32'(frame_done), 32'h0);
        chk("rst_idx", 32'(digit_idx), 32'h0);
        reset = 1'b1;

        // basic scan of 3210
        load = 1'b1; value = 16'h3210;
        tick();
        load = 1'b0; enable = 1'b1;
        run(64);

        // per-digit blank and decimal point
        load = 1'b1; blank_in = 4'b0100; dp_in = 4'b0001;
        tick();
        load = 1'b0;
        run(40);

        // enable dropped at cnt 5 of slot 1
        align(SL*D, SL + 5);
        enable = 1'b0;
        run(10);
        enable = 1'b1;
        run(12);

        // mid-slot load of FEDC at cnt 4 of slot 0
        align(SL*D, 4);
        load = 1'b1; value = 16'hFEDC; blank_in = '0; dp_in = '0;
        tick();
        load = 1'b0;
        run(20);

        // nibble sweep through digit 0
        for (int n = 0; n < 16; n++) begin
            align(SL*D, 0);
            load = 1'b1; value = 16'(n);
            tick();
            load = 1'b0;
            run(SL);
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            enable   = ($urandom_range(0, 7) != 0);
            load     = ($urandom_range(0, 11) == 0);
            value    = 16'($urandom);
            dp_in    = 4'($urandom);
            blank_in = 4'($urandom) & 4'($urandom);
            tick();
        end

        // asynchronous reset while driving
        enable = 1'b1; load = 1'b1; blank_in = '0; dp_in = 4'hF; value = 16'h8888;
        tick();
        load = 1'b0;
        align(SL, 5);
        chk("pre_rst_an", 32'(an == 4'hF), 32'h0);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_dp", 32'(dp), 32'h1);
        chk("arst_idx", 32'(digit_idx), 32'h0);
        pos = 0; m_val = '0; m_dp = '0; m_blank = '0;
        #2;
        reset = 1'b1;
        run(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
